// File: rtl/raw_req_sequencer_if.sv
// Request/valid handshake bundle between the bench/top control and the raw request sequencer.
// The slave modport is the sequencer's view; master is the controlling side.
interface raw_req_sequencer_if #(
    parameter int unsigned CNT_WIDTH = 12
) ();
    logic                 start_in;
    logic                 abort_in;
    logic [CNT_WIDTH-1:0] num_frames_in;
    logic                 sink_ready_in;
    logic                 data_valid_in;
    logic                 data_req_out;
    logic                 line_start_out;
    logic                 frame_start_out;
    logic                 frame_done_out;
    logic                 done_out;
    logic                 busy_out;
    logic                 err_out;
    logic [CNT_WIDTH-1:0] frames_done_out;

    modport slave (
        input  start_in, abort_in, num_frames_in, sink_ready_in, data_valid_in,
        output data_req_out, line_start_out, frame_start_out, frame_done_out,
        output done_out, busy_out, err_out, frames_done_out
    );

    modport master (
        output start_in, abort_in, num_frames_in, sink_ready_in, data_valid_in,
        input  data_req_out, line_start_out, frame_start_out, frame_done_out,
        input  done_out, busy_out, err_out, frames_done_out
    );
endinterface

// File: rtl/raw_req_sequencer.sv
// Drives the raw generator's data_req with line bursts, H/V blanking and a frame count,
// and checks that each line returns exactly HSIZE valid strobes.
module raw_req_sequencer #(
    parameter int unsigned HSIZE     = 6,
    parameter int unsigned VSIZE     = 6,
    parameter int unsigned H_BLANK   = 3,
    parameter int unsigned V_BLANK   = 2,
    parameter int unsigned CNT_WIDTH = 12
) (
    input logic                clk_in,
    input logic                rst_in,
    raw_req_sequencer_if.slave bus
);
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StWaitRdy = 3'd1;
    localparam logic [2:0] StLine    = 3'd2;
    localparam logic [2:0] StHblank  = 3'd3;
    localparam logic [2:0] StVblank  = 3'd4;
    localparam logic [2:0] StDone    = 3'd5;

    localparam logic [CNT_WIDTH-1:0] PixLast  = CNT_WIDTH'(HSIZE - 1);
    localparam logic [CNT_WIDTH-1:0] LineLast = CNT_WIDTH'(VSIZE - 1);
    localparam logic [CNT_WIDTH-1:0] HbLast   = CNT_WIDTH'(H_BLANK - 1);
    localparam logic [CNT_WIDTH-1:0] VbLast   = CNT_WIDTH'(V_BLANK - 1);
    localparam logic [CNT_WIDTH-1:0] HsizeC   = CNT_WIDTH'(HSIZE);
    localparam logic [CNT_WIDTH-1:0] ValidMax = CNT_WIDTH'(HSIZE + 1);

    logic [2:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] pix_q, pix_d;
    logic [CNT_WIDTH-1:0] blk_q, blk_d;
    logic [CNT_WIDTH-1:0] line_q, line_d;
    logic [CNT_WIDTH-1:0] valid_q, valid_d;
    logic [CNT_WIDTH-1:0] frames_q, frames_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic                 err_q, err_d;

    logic                 count_valid;
    logic [CNT_WIDTH-1:0] valid_inc;
    logic [CNT_WIDTH-1:0] frames_inc;

    // Late valids landing in HBLANK still belong to the line just requested.
    assign count_valid = (state_q == StLine || state_q == StHblank) && bus.data_valid_in &&
                         (valid_q != ValidMax);
    assign valid_inc   = count_valid ? valid_q + 1'b1 : valid_q;
    assign frames_inc  = frames_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        blk_d    = blk_q;
        line_d   = line_q;
        valid_d  = valid_inc;
        frames_d = frames_q;
        num_d    = num_q;
        err_d    = err_q;
        if (bus.abort_in) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start_in) begin
                        state_d  = StWaitRdy;
                        num_d    = bus.num_frames_in;
                        line_d   = '0;
                        frames_d = '0;
                        err_d    = 1'b0;
                    end
                end
                StWaitRdy: begin
                    if (bus.sink_ready_in) begin
                        state_d = StLine;
                        pix_d   = '0;
                        valid_d = '0;
                    end
                end
                StLine: begin
                    if (pix_q == PixLast) begin
                        state_d = StHblank;
                        blk_d   = '0;
                    end else begin
                        pix_d = pix_q + 1'b1;
                    end
                end
                StHblank: begin
                    if (blk_q == HbLast) begin
                        if (valid_inc != HsizeC) err_d = 1'b1;
                        if (line_q != LineLast) begin
                            line_d  = line_q + 1'b1;
                            state_d = StWaitRdy;
                        end else begin
                            frames_d = frames_inc;
                            if (num_q != '0 && frames_inc == num_q) begin
                                state_d = StDone;
                            end else begin
                                line_d  = '0;
                                blk_d   = '0;
                                state_d = (V_BLANK == 0) ? StWaitRdy : StVblank;
                            end
                        end
                    end else begin
                        blk_d = blk_q + 1'b1;
                    end
                end
                StVblank: begin
                    if (blk_q == VbLast) state_d = StWaitRdy;
                    else blk_d = blk_q + 1'b1;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= StIdle;
            pix_q    <= '0;
            blk_q    <= '0;
            line_q   <= '0;
            valid_q  <= '0;
            frames_q <= '0;
            num_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            blk_q    <= blk_d;
            line_q   <= line_d;
            valid_q  <= valid_d;
            frames_q <= frames_d;
            num_q    <= num_d;
            err_q    <= err_d;
        end
    end

    assign bus.data_req_out    = (state_q == StLine);
    assign bus.line_start_out  = (state_q == StLine) && (pix_q == '0);
    assign bus.frame_start_out = bus.line_start_out && (line_q == '0);
    assign bus.frame_done_out  = (state_q == StHblank) && (blk_q == HbLast) && (line_q == LineLast);
    assign bus.done_out        = (state_q == StDone);
    assign bus.busy_out        = (state_q != StIdle);
    assign bus.err_out         = err_q;
    assign bus.frames_done_out = frames_q;
endmodule

// File: tb/tb_raw_req_sequencer.sv
// Scoreboard bench for raw_req_sequencer: directed runs push expected events into queues,
// a negedge monitor pops and compares them as the DUT produces line/frame/done events.
module tb_raw_req_sequencer;
    localparam int unsigned CW = 12;
    localparam int LP = 10;  // 1 + HSIZE + H_BLANK
    localparam int FP = 62;  // VSIZE * LP + V_BLANK

    typedef struct { int len; int gap; } line_exp_t;
    typedef struct { int fdone; int err; } fd_exp_t;
    typedef struct { int lat; int fdone; int err; int gap_fd; } done_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    raw_req_sequencer_if #(.CNT_WIDTH(CW)) bus ();

    raw_req_sequencer #(
        .HSIZE(6), .VSIZE(6), .H_BLANK(3), .V_BLANK(2), .CNT_WIDTH(CW)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator model: echoes each request as a valid two cycles later, optionally dropping
    // the first valid of line 4.
    logic       pipe0 = 1'b0, pipe1 = 1'b0, drop_en = 1'b0;
    logic [3:0] line_idx = 4'd0;
    logic [3:0] this_line;
    assign this_line = bus.frame_start_out ? 4'd0 :
                       (bus.line_start_out ? line_idx + 4'd1 : line_idx);
    always @(posedge clk) begin
        line_idx <= this_line;
        pipe0    <= bus.data_req_out && !(drop_en && bus.line_start_out && this_line == 4'd4);
        pipe1    <= pipe0;
    end
    assign bus.data_valid_in = pipe1;

    line_exp_t q_line[$];
    int        q_fs[$];
    fd_exp_t   q_fd[$];
    done_exp_t q_done[$];

    int start_cyc = 0, last_ls = 0, last_fs = 0, last_fd = 0, burst_cyc = 0, line_gap = 0;
    int ls_count = 0, fs_count = 0, fd_count = 0, done_count = 0;
    bit fs_first = 1'b0;
    bit prev_req = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_%s: event seen with no expectation queued (cycle %0d)", name, cyc);
    endtask

    // Monitor
    initial begin
        line_exp_t le;
        fd_exp_t   fe;
        done_exp_t de;
        int        fg;
        forever begin
            @(negedge clk);
            if (bus.data_req_out && !prev_req) burst_cyc = cyc;
            if (bus.line_start_out) begin
                line_gap = cyc - last_ls;
                last_ls  = cyc;
                ls_count++;
            end
            if (!bus.data_req_out && prev_req) begin
                if (q_line.size() == 0) unexpected("line");
                else begin
                    le = q_line.pop_front();
                    chk("line_len", cyc - burst_cyc, le.len);
                    if (le.gap != 0) chk("line_gap", line_gap, le.gap);
                end
            end
            prev_req = bus.data_req_out;
            if (bus.frame_start_out) begin
                fg       = fs_first ? cyc - start_cyc : cyc - last_fs;
                fs_first = 1'b0;
                last_fs  = cyc;
                fs_count++;
                if (q_fs.size() == 0) unexpected("frame_start");
                else chk("frame_start_gap", fg, q_fs.pop_front());
            end
            if (bus.frame_done_out) begin
                last_fd = cyc;
                fd_count++;
                if (q_fd.size() == 0) unexpected("frame_done");
                else begin
                    fe = q_fd.pop_front();
                    chk("frame_done_count", int'(bus.frames_done_out), fe.fdone);
                    chk("frame_done_err", int'(bus.err_out), fe.err);
                end
            end
            if (bus.done_out) begin
                done_count++;
                if (q_done.size() == 0) unexpected("done");
                else begin
                    de = q_done.pop_front();
                    chk("done_latency", cyc - start_cyc, de.lat);
                    chk("done_frames", int'(bus.frames_done_out), de.fdone);
                    chk("done_err", int'(bus.err_out), de.err);
                    chk("done_after_frame_done", cyc - last_fd, de.gap_fd);
                end
            end
        end
    end

    task automatic push_frames(input int nframes);
        for (int f = 0; f < nframes; f++)
            for (int l = 0; l < 6; l++)
                q_line.push_back('{6, (f == 0 && l == 0) ? 0 : (l == 0 ? LP + 2 : LP)});
    endtask

    task automatic do_start(input int n);
        @(posedge clk);
        #1;
        bus.num_frames_in = CW'(n);
        bus.start_in      = 1'b1;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        start_cyc    = cyc;
        fs_first     = 1'b1;
        ls_count     = 0;
        fs_count     = 0;
        chk("start_busy", int'(bus.busy_out), 1);
        chk("start_err_clear", int'(bus.err_out), 0);
        chk("start_frames_clear", int'(bus.frames_done_out), 0);
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_count == d0; i++) @(posedge clk);
        chk("done_seen", done_count - d0, 1);
    endtask

    task automatic wait_ls(input int n, input int budget);
        for (int i = 0; i < budget && ls_count < n; i++) @(posedge clk);
        chk("line_start_seen", ls_count, n);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, int'(bus.data_req_out), 0);
        chk({tag, "_line_start"}, int'(bus.line_start_out), 0);
        chk({tag, "_frame_start"}, int'(bus.frame_start_out), 0);
        chk({tag, "_frame_done"}, int'(bus.frame_done_out), 0);
        chk({tag, "_done"}, int'(bus.done_out), 0);
        chk({tag, "_busy"}, int'(bus.busy_out), 0);
        chk({tag, "_err"}, int'(bus.err_out), 0);
        chk({tag, "_frames"}, int'(bus.frames_done_out), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst               = 1'b1;
        bus.start_in      = 1'b0;
        bus.abort_in      = 1'b0;
        bus.num_frames_in = '0;
        bus.sink_ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Single frame
        push_frames(1);
        q_fs.push_back(1);
        q_fd.push_back('{0, 0});
        q_done.push_back('{60, 1, 0, 1});
        d0 = done_count;
        do_start(1);
        wait_done(d0, 200);
        repeat (2) @(posedge clk);
        #1;
        chk("t1_frames_idle", int'(bus.frames_done_out), 1);

        // Three frames
        push_frames(3);
        q_fs.push_back(1);
        q_fs.push_back(FP);
        q_fs.push_back(FP);
        for (int f = 0; f < 3; f++) q_fd.push_back('{f, 0});
        q_done.push_back('{184, 3, 0, 1});
        d0 = done_count;
        do_start(3);
        wait_done(d0, 400);
        #1;
        chk("t2_frames_idle", int'(bus.frames_done_out), 3);

        // Backpressure: ready low through line 1 and 5 extra cycles before line 2
        for (int l = 0; l < 6; l++) q_line.push_back('{6, l == 0 ? 0 : (l == 2 ? LP + 5 : LP)});
        q_fs.push_back(1);
        q_fd.push_back('{0, 0});
        q_done.push_back('{65, 1, 0, 1});
        d0 = done_count;
        do_start(1);
        wait_ls(2, 100);
        #1;
        bus.sink_ready_in = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        bus.sink_ready_in = 1'b1;
        wait_done(d0, 200);

        // Dropped valid on line 4
        drop_en = 1'b1;
        push_frames(1);
        q_fs.push_back(1);
        q_fd.push_back('{0, 1});
        q_done.push_back('{60, 1, 1, 1});
        d0 = done_count;
        do_start(1);
        wait_done(d0, 200);
        drop_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t4_err_sticky", int'(bus.err_out), 1);

        // Abort in the third request cycle of line 1
        q_line.push_back('{6, 0});
        q_line.push_back('{3, LP});
        q_fs.push_back(1);
        d0 = done_count;
        do_start(1);
        wait_ls(2, 100);
        @(posedge clk);
        #1;
        bus.abort_in = 1'b1;
        @(posedge clk);
        #1;
        bus.abort_in = 1'b0;
        chk("abort_req", int'(bus.data_req_out), 0);
        chk("abort_busy", int'(bus.busy_out), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", done_count, d0);
        bus.start_in = 1'b1;
        bus.abort_in = 1'b1;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        bus.abort_in = 1'b0;
        chk("start_with_abort_busy", int'(bus.busy_out), 0);
        push_frames(1);
        q_fs.push_back(1);
        q_fd.push_back('{0, 0});
        q_done.push_back('{60, 1, 0, 1});
        do_start(1);
        wait_done(d0, 200);

        // Continuous mode, then reset mid-line of the seventh frame
        push_frames(6);
        q_line.push_back('{4, LP + 2});
        q_fs.push_back(1);
        for (int f = 0; f < 6; f++) begin
            q_fs.push_back(FP);
            q_fd.push_back('{f, 0});
        end
        do_start(0);
        for (int i = 0; i < 600 && fs_count < 7; i++) @(posedge clk);
        chk("t6_frame_starts", fs_count, 7);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_frames_before_reset", int'(bus.frames_done_out), 6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("midrun_reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        chk("left_line", q_line.size(), 0);
        chk("left_frame_start", q_fs.size(), 0);
        chk("left_frame_done", q_fd.size(), 0);
        chk("left_done", q_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/raw_req_sequencer.md
# raw_req_sequencer

Frame/line request sequencer for the raw pixel generator in the test-bench datapath. On command it drives the generator's `data_req` input with exact line bursts, horizontal and vertical blanking, and a programmable frame count, gated by downstream readiness. It also counts the returned `data_valid` pulses per line and flags short or long lines. It sits between the bench/top-level control and the raw data generator, and owns all request timing for it.

## Interface
Parameters:
- `HSIZE`, default 6: pixels requested per line (≥1).
- `VSIZE`, default 6: lines per frame (≥1).
- `H_BLANK`, default 3: request-low cycles after each line burst (≥1).
- `V_BLANK`, default 2: extra idle cycles after each frame (≥0).
- `CNT_WIDTH`, default 12: width of frame/line/pixel counters.

Ports (reset is synchronous and active-high; all logic on `clk_in`):
- `clk_in`, in, 1: clock.
- `rst_in`, in, 1: synchronous active-high reset.
- `start_in`, in, 1: start pulse; accepted only in IDLE.
- `abort_in`, in, 1: stop immediately and return to IDLE.
- `num_frames_in`, in, CNT_WIDTH: frames to run; sampled on start. 0 means continuous.
- `sink_ready_in`, in, 1: downstream can accept a line; sampled only in WAIT_RDY.
- `data_valid_in`, in, 1: valid strobe returned by the generator.
- `data_req_out`, out, 1: request to the generator.
- `line_start_out`, out, 1: 1-cycle pulse on the first request cycle of each line.
- `frame_start_out`, out, 1: 1-cycle pulse coincident with `line_start_out` of line 0.
- `frame_done_out`, out, 1: 1-cycle pulse on the last HBLANK cycle of line VSIZE-1.
- `done_out`, out, 1: 1-cycle pulse in state DONE.
- `busy_out`, out, 1: high in every state except IDLE.
- `err_out`, out, 1: sticky line-length error.
- `frames_done_out`, out, CNT_WIDTH: completed-frame counter.

## Operation
States: IDLE, WAIT_RDY, LINE, HBLANK, VBLANK, DONE. Outputs are decoded from registered state and counters only.

- **IDLE**
  - `start_in`=1 and `abort_in`=0 → WAIT_RDY.
  - On that transition: latch `num_frames_in`, clear line_cnt and `frames_done_out`, clear `err_out`.
- **WAIT_RDY**
  - `sink_ready_in`=1 → LINE; otherwise hold.
- **LINE**
  - `data_req_out`=1 for exactly HSIZE cycles; pix_cnt runs 0..HSIZE-1.
  - Then → HBLANK.
  - valid_cnt clears on entry.
- **HBLANK**
  - H_BLANK cycles with request low.
  - On the last cycle, compare valid_cnt with HSIZE; a mismatch sets `err_out`.
  - If line_cnt < VSIZE-1: line_cnt+1, → WAIT_RDY.
  - Else, frame end:
    - pulse `frame_done_out` and increment `frames_done_out` (wraps modulo 2^CNT_WIDTH).
    - If latched N≠0 and the incremented count equals N → DONE.
    - Otherwise clear line_cnt and → VBLANK, or → WAIT_RDY if V_BLANK=0.
- **VBLANK**
  - V_BLANK cycles, then → WAIT_RDY.
- **DONE**
  - One cycle, `done_out`=1, → IDLE.

Validity counting:
- valid_cnt increments on `data_valid_in` in LINE and HBLANK only, and saturates at HSIZE+1.
- Valids seen in any other state are ignored.

Priority and boundary rules:
- `abort_in` has highest priority. In any state, including IDLE with `start_in` asserted, the next state is IDLE.
  - Abort produces no `frame_done_out` and no `done_out`.
  - Abort does not change `frames_done_out` or `err_out`.
- `start_in` while busy is ignored.
- `sink_ready_in` dropping during LINE does not interrupt the burst.
- Continuous mode (N=0) runs until abort.

## Timing
Reset values (after `rst_in`=1 at a clock edge):
- state IDLE.
- all outputs 0.
- `frames_done_out`=0.

Request latency and line/frame timing:
- Start accepted at edge k: WAIT_RDY in cycle k+1.
- With `sink_ready_in`=1, `data_req_out` is high in cycles k+2..k+1+HSIZE.
- Line period with ready held high: 1+HSIZE+H_BLANK cycles.
- Frame period: VSIZE·(1+HSIZE+H_BLANK)+V_BLANK.

Error-check timing:
- Generator valid latency must be ≤ H_BLANK cycles after the last request. A longer latency is reported as an error.

Abort timing:
- Abort sampled at edge k: `data_req_out`=0 and `busy_out`=0 from cycle k+1.

Reset mid-operation:
- `rst_in` has the same effect as abort, and additionally clears all counters and `err_out`.

## Test plan
1. Single frame at default parameters, N=1, ready tied high, generator echoing valid 2 cycles after each request.
   - 6 bursts of 6 request cycles, each separated by 3 low cycles plus 1 WAIT_RDY cycle.
   - `frame_done_out` once; `done_out` 60 cycles after start accepted; `err_out`=0; `frames_done_out`=1.
2. N=3:
   - 3 `frame_start_out` pulses, each 62 cycles apart.
   - `frames_done_out` goes 1, 2, 3; `done_out` follows the third `frame_done_out` by 1 cycle.
3. Backpressure: `sink_ready_in` low for 5 cycles before line 2.
   - Request stays low for those 5 cycles; line 2 burst still lasts 6 cycles.
   - Dropping ready mid-burst does not shorten it.
4. Drop one valid on line 4.
   - `err_out` rises on the last HBLANK cycle of line 4 and stays high through `done_out`.
   - Next `start_in` clears it.
5. Abort during the 3rd request cycle of line 1.
   - Request and busy are low the next cycle; no `done_out`.
   - `start_in` asserted together with `abort_in` in IDLE is ignored.
   - `start_in` then restarts from line 0.
6. N=0 continuous mode:
   - More than 5 frames complete; `frames_done_out` increments each frame.
   - Synchronous `rst_in` mid-frame returns all outputs to 0.
